// File: rtl/bf16_mul_tree_param.sv
// bf16_mul_tree_param
//   Multiplies N_LEAF bf16 operands in a balanced binary tree of
//   mul_3_stage_pipe_bf16 instances. Each transaction selects a group size
//   of 2^(mode+1) operands. Masked operands are replaced by 1.0. Latency is
//   fixed at LEVELS*(MUL_LAT+1) cycles for every mode, so transactions in
//   different modes can be issued back to back.
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset
//   mul_ins   operand i at [16*i+15:16*i]
//   op_mask   1 = operand used, 0 = operand replaced by 1.0 (16'h3F80)
//   mode      group size 2^(mode+1); values >= LEVELS act as LEVELS-1
//   mul_stb   transaction valid (one per cycle, no back-pressure)
//   outputs   group products, group g on lane g, unused lanes 0
//   out_stbs  per-lane result valid, one-cycle pulse per transaction
//   out_mode  (clamped) mode of the transaction currently presented
//   busy      at least one transaction in flight
//
// mul_3_stage_pipe_bf16 (same file)
//   Three-cycle bf16 multiplier: round-to-nearest-even, subnormal inputs
//   and results flushed to signed zero, overflow to infinity, NaN results
//   returned as 16'h7FC0. MUL_LAT must match its latency of 3.

module mul_3_stage_pipe_bf16 (
    input  logic        clk,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o
);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        a_zero = (a_i[14:7] == 8'h00);
        b_zero = (b_i[14:7] == 8'h00);
        a_inf  = (a_i[14:7] == 8'hFF) && (a_i[6:0] == 7'h00);
        b_inf  = (b_i[14:7] == 8'hFF) && (b_i[6:0] == 7'h00);
        a_nan  = (a_i[14:7] == 8'hFF) && (a_i[6:0] != 7'h00);
        b_nan  = (b_i[14:7] == 8'hFF) && (b_i[6:0] != 7'h00);
    end

    // Stage 1: sign, biased exponent sum, 8x8 significand product, specials.
    logic              s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic signed [9:0] s1_exp_q;
    logic [15:0]       s1_prod_q;

    // NOTE: datapath registers are not reset; the strobe pipeline alone decides when data is meaningful.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        s1_sign_q <= a_i[15] ^ b_i[15];
        s1_exp_q  <= $signed({2'b00, a_i[14:7]}) + $signed({2'b00, b_i[14:7]}) - 10'sd127;
        s1_prod_q <= {1'b1, a_i[6:0]} * {1'b1, b_i[6:0]};
        s1_nan_q  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_inf_q  <= a_inf | b_inf;
        s1_zero_q <= a_zero | b_zero;
    end

    // Stage 2: normalise the product to 1.xxxxxxx and decide the RNE increment.
    logic [7:0]        s2_mant_d, s2_mant_q;
    logic signed [9:0] s2_exp_d, s2_exp_q;
    logic              s2_rnd_d, s2_rnd_q;
    logic              guard, sticky;
    logic              s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;

    always_comb begin
        if (s1_prod_q[15]) begin
            s2_mant_d = s1_prod_q[15:8];
            guard     = s1_prod_q[7];
            sticky    = |s1_prod_q[6:0];
            s2_exp_d  = s1_exp_q + 10'sd1;
        end else begin
            s2_mant_d = s1_prod_q[14:7];
            guard     = s1_prod_q[6];
            sticky    = |s1_prod_q[5:0];
            s2_exp_d  = s1_exp_q;
        end
        s2_rnd_d = guard & (sticky | s2_mant_d[0]);
    end

    always_ff @(posedge clk) begin
        s2_mant_q <= s2_mant_d;
        s2_exp_q  <= s2_exp_d;
        s2_rnd_q  <= s2_rnd_d;
        s2_sign_q <= s1_sign_q;
        s2_nan_q  <= s1_nan_q;
        s2_inf_q  <= s1_inf_q;
        s2_zero_q <= s1_zero_q;
    end

    // Stage 3: apply rounding (a carry out renormalises) and select specials.
    logic [8:0]        rnd_sum;
    logic signed [9:0] exp_f;
    logic [6:0]        frac_f;
    logic [15:0]       p_d, p_q;

    always_comb begin
        rnd_sum = {1'b0, s2_mant_q} + {8'h00, s2_rnd_q};
        exp_f   = rnd_sum[8] ? s2_exp_q + 10'sd1 : s2_exp_q;
        frac_f  = rnd_sum[8] ? rnd_sum[7:1] : rnd_sum[6:0];
        if (s2_nan_q)              p_d = 16'h7FC0;
        else if (s2_inf_q)         p_d = {s2_sign_q, 8'hFF, 7'h00};
        else if (s2_zero_q)        p_d = {s2_sign_q, 15'h0000};
        else if (exp_f >= 10'sd255) p_d = {s2_sign_q, 8'hFF, 7'h00};
        else if (exp_f <= 10'sd0)  p_d = {s2_sign_q, 15'h0000};
        else                       p_d = {s2_sign_q, exp_f[7:0], frac_f};
    end

    always_ff @(posedge clk) begin
        p_q <= p_d;
    end

    assign p_o = p_q;
endmodule

module bf16_mul_tree_param #(
    parameter  int N_LEAF  = 8,
    parameter  int MUL_LAT = 3,
    localparam int LEVELS  = $clog2(N_LEAF),
    localparam int MODE_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_LEAF*16-1:0]     mul_ins,
    input  logic [N_LEAF-1:0]        op_mask,
    input  logic [MODE_W-1:0]        mode,
    input  logic                     mul_stb,
    output logic [(N_LEAF/2)*16-1:0] outputs,
    output logic [N_LEAF/2-1:0]      out_stbs,
    output logic [MODE_W-1:0]        out_mode,
    output logic                     busy
);
    localparam int HALF  = N_LEAF / 2;
    localparam int L     = MUL_LAT + 1;
    localparam int T     = LEVELS * L;
    localparam int CNT_W = $clog2(T + 1);
    // Tag index aligned with the last level's multiplier outputs.
    localparam int FIN   = T - 2;

    logic [N_LEAF*16-1:0] leaf_ops;
    logic [MODE_W-1:0]    mode_clamped;

    always_comb begin
        for (int i = 0; i < N_LEAF; i++) begin
            leaf_ops[16*i +: 16] = op_mask[i] ? mul_ins[16*i +: 16] : 16'h3F80;
        end
        mode_clamped = (int'(mode) >= LEVELS) ? MODE_W'(LEVELS - 1) : mode;
    end

    // Strobe and mode tags travel alongside the data; tag p is seen p+1
    // cycles after the strobe. The output registers form the final stage.
    logic [T-2:0]      stb_q;
    logic [MODE_W-1:0] mode_q [T-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q <= '0;
            for (int p = 0; p < T - 1; p++) mode_q[p] <= '0;
        end else begin
            stb_q     <= {stb_q[T-3:0], mul_stb};
            mode_q[0] <= mode_clamped;
            for (int p = 1; p < T - 1; p++) mode_q[p] <= mode_q[p-1];
        end
    end

    // Each level ends in one register holding HALF lanes: products where the
    // level is active, otherwise the level input delayed to match.
    logic [HALF*16-1:0] lvl_d [LEVELS];
    logic [HALF*16-1:0] lvl_q [LEVELS];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NM  = N_LEAF >> (k + 1);
        localparam int TAG = k * L + MUL_LAT - 1;
        logic [HALF*16-1:0] byp;

        if (k == 0) begin : g_nobyp
            assign byp = '0;
        end else begin : g_byp
            logic [HALF*16-1:0] dly_q [MUL_LAT];
            always_ff @(posedge clk) begin
                dly_q[0] <= lvl_q[k-1];
                for (int i = 1; i < MUL_LAT; i++) dly_q[i] <= dly_q[i-1];
            end
            assign byp = dly_q[MUL_LAT-1];
        end

        for (genvar j = 0; j < HALF; j++) begin : g_lane
            logic [15:0] prod;
            logic        use_mul, lane_ok;

            if (j < NM) begin : g_mul
                logic [15:0] a, b;
                if (k == 0) begin : g_src_leaf
                    assign a = leaf_ops[32*j +: 16];
                    assign b = leaf_ops[32*j+16 +: 16];
                end else begin : g_src_lvl
                    assign a = lvl_q[k-1][32*j +: 16];
                    assign b = lvl_q[k-1][32*j+16 +: 16];
                end
                mul_3_stage_pipe_bf16 u_mul (
                    .clk (clk),
                    .a_i (a),
                    .b_i (b),
                    .p_o (prod)
                );
            end else begin : g_nomul
                assign prod = 16'h0000;
            end

            assign use_mul = (j < NM) && (k <= int'(mode_q[TAG]));

            // Only the last level knows the final group count; it zeroes
            // lanes beyond it and idles the bus between transactions.
            if (k == LEVELS - 1) begin : g_last
                assign lane_ok = stb_q[TAG] && (j < (N_LEAF >> (int'(mode_q[TAG]) + 1)));
            end else begin : g_mid
                assign lane_ok = 1'b1;
            end

            assign lvl_d[k][16*j +: 16] = !lane_ok ? 16'h0000 :
                                          use_mul  ? prod     : byp[16*j +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LEVELS; k++) lvl_q[k] <= '0;
        end else begin
            for (int k = 0; k < LEVELS; k++) lvl_q[k] <= lvl_d[k];
        end
    end

    // Strobes, presented mode and in-flight count.
    logic [HALF-1:0]   stbs_q;
    logic [MODE_W-1:0] out_mode_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        // Lane 0 is valid in every mode, so it marks the final strobe.
        case ({mul_stb, stbs_q[0]})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stbs_q     <= '0;
            out_mode_q <= '0;
            cnt_q      <= '0;
        end else begin
            for (int j = 0; j < HALF; j++) begin
                stbs_q[j] <= stb_q[FIN] && (j < (N_LEAF >> (int'(mode_q[FIN]) + 1)));
            end
            if (stb_q[FIN]) out_mode_q <= mode_q[FIN];
            cnt_q <= cnt_d;
        end
    end

    assign outputs  = lvl_q[LEVELS-1];
    assign out_stbs = stbs_q;
    assign out_mode = out_mode_q;
    assign busy     = (cnt_q != '0);
endmodule
